// File: rtl/inst_fetch_rom_if.sv
// Fetch-side bus between the control sequencer (master) and inst_fetch_rom (slave).
// INST_FETCH_ROM_PARITY_EN adds the out_par signal.
interface inst_fetch_rom_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              start;
   logic              stop;
   logic              jmp_vld;
   logic [ADDR_W-1:0] jmp_addr;
   logic              out_ready;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              busy;
`ifdef INST_FETCH_ROM_PARITY_EN
   logic              out_par;
`endif

   modport master (
      output start, stop, jmp_vld, jmp_addr, out_ready,
`ifdef INST_FETCH_ROM_PARITY_EN
      input  out_par,
`endif
      input  out_valid, out_addr, out_data, busy
   );

   modport slave (
      input  start, stop, jmp_vld, jmp_addr, out_ready,
`ifdef INST_FETCH_ROM_PARITY_EN
      output out_par,
`endif
      output out_valid, out_addr, out_data, busy
   );
endinterface

// File: rtl/inst_fetch_rom.sv
// Clocked instruction fetch: program counter + fixed ROM with registered read, valid/ready output.
// Define INST_FETCH_ROM_PARITY_EN to add the out_par even-parity output.
module inst_fetch_rom #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int WRAP_LO = 1,
   parameter int WRAP_HI = 15
) (
   input  logic clk,
   input  logic rst,
   inst_fetch_rom_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic              busy_reg;

   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   logic              valid_reg;

   logic              slot_free;
   logic              do_flush;
   logic              do_fetch;
   logic              do_drain;

   // Fixed program image: mem[a] = (a*37 + 5) mod 2^DATA_W.
   logic [DATA_W-1:0] rom_mem [0:DEPTH-1];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
         assign rom_mem[gi] = DATA_W'(gi * 37 + 5);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next == RUN);
      end
   end

   // Stop dominates start when both arrive together.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start && !bus.stop) state_next = RUN;
         RUN:     if (bus.stop)               state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      slot_free = !valid_reg || bus.out_ready;
      do_flush  = bus.jmp_vld;
      do_fetch  = 1'b0;
      do_drain  = 1'b0;
      if (!bus.jmp_vld && slot_free) begin
         if (state_reg == RUN && !bus.stop) begin
            do_fetch = 1'b1;
         end else begin
            do_drain = 1'b1;
         end
      end
   end

   // The wrap window only applies at exactly WRAP_HI; above it the PC rolls over naturally.
   always_comb begin
      if (pc_reg == ADDR_W'(WRAP_HI)) begin
         pc_next = ADDR_W'(WRAP_LO);
      end else begin
         pc_next = pc_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_reg    <= '0;
         addr_reg  <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (do_flush) begin
         pc_reg    <= bus.jmp_addr;
         valid_reg <= 1'b0;
      end else if (do_fetch) begin
         data_reg  <= rom_mem[pc_reg];
         addr_reg  <= pc_reg;
         valid_reg <= 1'b1;
         pc_reg    <= pc_next;
      end else if (do_drain) begin
         valid_reg <= 1'b0;
      end
   end

`ifdef INST_FETCH_ROM_PARITY_EN
   logic par_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         par_reg <= 1'b0;
      end else if (do_fetch && !do_flush) begin
         par_reg <= ^rom_mem[pc_reg];
      end
   end

   assign bus.out_par = par_reg;
`endif

   assign bus.out_valid = valid_reg;
   assign bus.out_addr  = addr_reg;
   assign bus.out_data  = data_reg;
   assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_inst_fetch_rom.sv
// Directed bench for inst_fetch_rom: start/stream, wrap, stall, jump, stop/start, reset.
module tb_inst_fetch_rom;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   inst_fetch_rom_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   inst_fetch_rom #(
      .ADDR_W (4),
      .DATA_W (8),
      .WRAP_LO(1),
      .WRAP_HI(15)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1ns later, inputs then change for the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input string tag, input logic [3:0] a, input logic [7:0] d);
      $display("vec %0d %s: valid=%0b addr=%0d data=%02h", n_vec, tag,
               bus.out_valid, bus.out_addr, bus.out_data);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".addr"},  32'(bus.out_addr),  32'(a));
      chk({tag, ".data"},  32'(bus.out_data),  32'(d));
`ifdef INST_FETCH_ROM_PARITY_EN
      chk({tag, ".par"},   32'(bus.out_par),   32'(^d));
`endif
   endtask

   task automatic expect_empty(input string tag, input logic b);
      $display("vec %0d %s: valid=%0b busy=%0b", n_vec, tag, bus.out_valid, bus.busy);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".busy"},  32'(bus.busy),      32'(b));
   endtask

   // Hand-computed (a*37+5) mod 256 for the addresses the vectors visit.
   logic [7:0] exp_rom [0:15] = '{8'h05, 8'h2A, 8'h4F, 8'h74, 8'h99, 8'hBE, 8'hE3, 8'h08,
                                  8'h2D, 8'h52, 8'h77, 8'h9C, 8'hC1, 8'hE6, 8'h0B, 8'h30};

   initial begin
      n_vec = 0;
      n_err = 0;
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.jmp_vld   = 1'b0;
      bus.jmp_addr  = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      expect_empty("reset", 1'b0);
      chk("reset.addr", 32'(bus.out_addr), 32'd0);
      chk("reset.data", 32'(bus.out_data), 32'd0);

      // Start pulse, consumer always ready.
      rst = 1'b1;
      step();
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      step();
      expect_empty("start", 1'b1);
      bus.start = 1'b0;
      step(); expect_word("w0", 4'd0, 8'h05);
      step(); expect_word("w1", 4'd1, 8'h2A);
      step(); expect_word("w2", 4'd2, exp_rom[2]);
      step(); expect_word("w3", 4'd3, 8'h74);

      // Stall three cycles on addr 3.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); expect_word("stall", 4'd3, 8'h74);
      end
      bus.out_ready = 1'b1;
      step(); expect_word("resume", 4'd4, exp_rom[4]);

      // Run to the top and across the wrap window.
      for (int a = 5; a < 16; a++) begin
         step(); expect_word("run", 4'(a), exp_rom[a]);
      end
      chk("top.data", 32'(bus.out_data), 32'h30);
      step(); expect_word("wrap", 4'd1, 8'h2A);
      step(); expect_word("wrap2", 4'd2, exp_rom[2]);

      // Jump with a word pending: one bubble, then the target.
      bus.jmp_vld  = 1'b1;
      bus.jmp_addr = 4'd5;
      step(); expect_empty("jmp.bubble", 1'b1);
      bus.jmp_vld = 1'b0;
      step(); expect_word("jmp.tgt", 4'd5, 8'hBE);
      step(); expect_word("jmp.next", 4'd6, exp_rom[6]);

      // Stop while addr 6 is stalled: word stays until accepted.
      bus.out_ready = 1'b0;
      bus.stop      = 1'b1;
      step(); expect_word("stop.hold", 4'd6, exp_rom[6]);
      chk("stop.busy", 32'(bus.busy), 32'd0);
      bus.stop = 1'b0;
      step(); expect_word("stop.hold2", 4'd6, exp_rom[6]);
      bus.out_ready = 1'b1;
      step(); expect_empty("stop.drain", 1'b0);

      // Start and stop together in IDLE: stop wins.
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step(); expect_empty("both", 1'b0);
      step(); expect_empty("both2", 1'b0);
      bus.stop = 1'b0;
      step(); expect_empty("restart", 1'b1);
      bus.start = 1'b0;
      step(); expect_word("resume.pc", 4'd7, 8'h08);

      // A reset glitch between edges is ignored.
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      step(); expect_word("glitch", 4'd8, exp_rom[8]);

      // Real reset mid-stream.
      rst = 1'b0;
      step(); expect_empty("rst.mid", 1'b0);
      chk("rst.addr", 32'(bus.out_addr), 32'd0);
      chk("rst.data", 32'(bus.out_data), 32'd0);
`ifdef INST_FETCH_ROM_PARITY_EN
      chk("rst.par", 32'(bus.out_par), 32'd0);
`endif
      rst = 1'b1;
      step(); expect_empty("rst.idle", 1'b0);
      bus.start = 1'b1;
      step(); expect_empty("rst.start", 1'b1);
      bus.start = 1'b0;
      step(); expect_word("rst.w0", 4'd0, 8'h05);

      // Jump while IDLE moves pc without producing output.
      bus.stop = 1'b1;
      step();
      bus.stop     = 1'b0;
      bus.jmp_vld  = 1'b1;
      bus.jmp_addr = 4'd12;
      step(); expect_empty("idle.jmp", 1'b0);
      bus.jmp_vld = 1'b0;
      bus.start   = 1'b1;
      step();
      bus.start = 1'b0;
      step(); expect_word("idle.jmp.w", 4'd12, exp_rom[12]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/inst_fetch_rom.md
Name: inst_fetch_rom

Overview:
- Parametrised, clocked successor to the combinational instruction ROM: an internal program counter drives a registered ROM read.
- Delivers instruction words through a valid/ready output handshake, with start/stop control, jump load and a configurable wrap window.
- Sits between the test/control sequencer and the instruction decoder; replaces the external address-counter-plus-ROM arrangement.

Parameters:
- ADDR_W, 4, PC and ROM address width; depth is 2^ADDR_W.
- DATA_W, 8, instruction word width.
- WRAP_LO, 1, address loaded into the PC after WRAP_HI is fetched.
- WRAP_HI, 15, last address before wrapping; must satisfy WRAP_LO <= WRAP_HI <= 2^ADDR_W-1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  pulse; enter RUN.
- stop  in  1  pulse; enter IDLE.
- jmp_vld  in  1  load PC from jmp_addr.
- jmp_addr  in  ADDR_W  jump target.
- out_ready  in  1  consumer accepts word.
- out_valid  out  1  out_data/out_addr valid.
- out_addr  out  ADDR_W  address of presented word.
- out_data  out  DATA_W  instruction word.
- busy  out  1  high in RUN.

Behaviour:
- ROM contents are fixed: mem[a] = (a*37 + 5) mod 2^DATA_W.
  - Defaults give 0x05 @0, 0x2A @1, 0x74 @3, 0xBE @5, 0x30 @15.
- Reset (rst==0 at posedge):
  - pc=0, state=IDLE, out_valid=0, out_addr=0, out_data=0, busy=0.
  - Reset overrides every other input; reset mid-stream discards any pending word.
- States: IDLE, RUN.
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop.
  - If start and stop are both high, stop wins (IDLE).
- Output slot is free when out_valid==0 or out_ready==1.
- In RUN with the slot free and no jmp_vld, at the next edge:
  - out_data=mem[pc], out_addr=pc, out_valid=1.
  - pc = (pc==WRAP_HI) ? WRAP_LO : pc+1.
  - Latency: one cycle from start to first out_valid.
- Stall: out_valid && !out_ready holds out_data, out_addr, out_valid and pc unchanged.
- Slot free but no fetch (IDLE, or stop this cycle): out_valid goes to 0 once the word is accepted.
- A word pending when stop arrives stays presented until accepted.
- pc is retained across IDLE; the next start resumes from pc.
- jmp_vld (any state) has priority over fetch:
  - pc=jmp_addr, out_valid=0 at the next edge; the pending word is flushed.
  - A simultaneous out_ready counts as consumed.
  - A jump issued in RUN produces the first word (jmp_addr) one cycle later; this is one bubble.
- Wrap:
  - A PC above WRAP_HI (reached only via jump) increments up to 2^ADDR_W-1, then wraps naturally to 0.
  - WRAP_LO/WRAP_HI apply only when pc==WRAP_HI exactly.
- Sustained throughput: one word per cycle with out_ready held high.
- busy = (state==RUN); registered, updates on the same edge as the state.

Optional Feature:
- Macro: INST_FETCH_ROM_PARITY_EN.
- Defined:
  - Adds output out_par (1 bit) = even parity (XOR reduce) of out_data.
  - out_par is registered alongside out_data, resets to 0 and holds during stalls.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then start pulse, out_ready=1 -> first out_valid one cycle later with addr 0 / 0x05, then 1/0x2A, 2, 3/0x74 ... one per cycle.
- Free-run past the top -> addr 15 / 0x30, then addr 1 / 0x2A (not 0); the sequence 1..15 repeats.
- At addr 3 presented, drop out_ready for 3 cycles -> addr 3 / 0x74 held, pc frozen; on the first ready=1 cycle the next word is addr 4.
- jmp_vld with jmp_addr=5 while RUN and a word pending -> out_valid=0 next cycle, then addr 5 / 0xBE, then 6.
- stop and start together in IDLE -> remains IDLE, busy=0; later stop while a word is pending with out_ready=0 -> word held until accepted, then out_valid=0; start -> resumes at saved pc.
- rst=0 asserted mid-stream with out_valid=1 -> next edge all outputs 0 and state IDLE; rst is sampled only on clk edges (a glitch between edges has no effect).
